// File: rtl/dmni_ni_ctrl.sv
// DMNI network-interface control: masked IRQ controller, BrLite TX queue, monitor pointers/clear.
// Optional receive-timestamp latch is built in when DMNI_RCV_TIMESTAMP_EN is defined.
module dmni_ni_ctrl #(
   parameter int unsigned N_IRQ    = 4,
   parameter int unsigned N_MON    = 2,
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned CFG_AW   = 5
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cfg_en_i,
   input  logic                cfg_we_i,
   input  logic [CFG_AW-1:0]   cfg_addr_i,
   input  logic [31:0]         cfg_data_i,
   output logic [31:0]         cfg_data_o,
   input  logic [N_IRQ-1:0]    irq_src_i,
   output logic                irq_o,
   output logic                br_req_o,
   input  logic                br_ack_i,
   output logic [1:0]          br_service_o,
   output logic [7:0]          br_ksvc_o,
   output logic [15:0]         br_target_o,
   output logic [31:0]         br_payload_o,
   output logic [N_MON*32-1:0] br_mon_ptrs_o,
   output logic                br_mon_clear_o,
   input  logic                br_mon_clear_ack_i,
   output logic [31:0]         br_mon_task_clear_o,
   input  logic                eop_acked_i,
   input  logic [31:0]         rcv_timestamp_i
);
   localparam int unsigned PW = $clog2(TX_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned RW = N_IRQ + 2;

   localparam logic [CFG_AW-1:0] AddrStatus  = CFG_AW'(0);
   localparam logic [CFG_AW-1:0] AddrIrqRaw  = CFG_AW'(1);
   localparam logic [CFG_AW-1:0] AddrIrqMask = CFG_AW'(2);
   localparam logic [CFG_AW-1:0] AddrIrqStat = CFG_AW'(3);
   localparam logic [CFG_AW-1:0] AddrService = CFG_AW'(4);
   localparam logic [CFG_AW-1:0] AddrKsvc    = CFG_AW'(5);
   localparam logic [CFG_AW-1:0] AddrTarget  = CFG_AW'(6);
   localparam logic [CFG_AW-1:0] AddrPayload = CFG_AW'(7);
   localparam logic [CFG_AW-1:0] AddrPush    = CFG_AW'(8);
   localparam logic [CFG_AW-1:0] AddrOvf     = CFG_AW'(9);
   localparam logic [CFG_AW-1:0] AddrMonClr  = CFG_AW'(10);
   localparam logic [CFG_AW-1:0] AddrRcvTs   = CFG_AW'(11);

   typedef struct packed {
      logic [1:0]  service;
      logic [7:0]  ksvc;
      logic [15:0] target;
      logic [31:0] payload;
   } br_entry_t;

   br_entry_t [TX_DEPTH-1:0] mem_q;
   br_entry_t                stage_q;
   logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]            count_q;
   logic [RW-1:0]            mask_q;
   logic                     ovf_q, tx_empty_q, clear_busy_q, irq_q;
   logic [31:0]              task_q, rdata_q, rd_data, ts_val;
   logic [N_MON-1:0][31:0]   mon_ptr_q;

   logic          wr_en, rd_en, push_req, push, pop, full, empty, mon_clr_start;
   logic [RW-1:0] irq_raw;

   assign wr_en    = cfg_en_i & cfg_we_i;
   assign rd_en    = cfg_en_i & ~cfg_we_i;
   assign full     = (count_q == CW'(TX_DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = br_ack_i & ~empty;
   assign push_req = wr_en & (cfg_addr_i == AddrPush);
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push     = push_req & (~full | pop);
   assign irq_raw  = {ovf_q, tx_empty_q, irq_src_i};
   assign mon_clr_start = wr_en & (cfg_addr_i == AddrMonClr) & ~clear_busy_q;

   always_comb begin
      rd_data = '0;
      case (cfg_addr_i)
         AddrStatus:  rd_data = {16'(count_q), 13'b0, clear_busy_q, full, empty};
         AddrIrqRaw:  rd_data = 32'(irq_raw);
         AddrIrqMask: rd_data = 32'(mask_q);
         AddrIrqStat: rd_data = 32'(irq_raw & mask_q);
         AddrService: rd_data = 32'(stage_q.service);
         AddrKsvc:    rd_data = 32'(stage_q.ksvc);
         AddrTarget:  rd_data = 32'(stage_q.target);
         AddrPayload: rd_data = stage_q.payload;
         AddrOvf:     rd_data = 32'(ovf_q);
         AddrRcvTs:   rd_data = ts_val;
         default:     rd_data = '0;
      endcase
      for (int unsigned i = 0; i < N_MON; i++) begin
         if (cfg_addr_i == CFG_AW'(16 + i)) rd_data = mon_ptr_q[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_q        <= '0;
         stage_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         mask_q       <= '0;
         ovf_q        <= 1'b0;
         tx_empty_q   <= 1'b0;
         clear_busy_q <= 1'b0;
         irq_q        <= 1'b0;
         task_q       <= '0;
         rdata_q      <= '0;
         mon_ptr_q    <= '0;
      end else begin
         if (rd_en) rdata_q <= rd_data;
         irq_q <= |(irq_raw & mask_q);
         if (wr_en) begin
            case (cfg_addr_i)
               AddrIrqMask: mask_q          <= cfg_data_i[RW-1:0];
               AddrService: stage_q.service <= cfg_data_i[1:0];
               AddrKsvc:    stage_q.ksvc    <= cfg_data_i[7:0];
               AddrTarget:  stage_q.target  <= cfg_data_i[15:0];
               AddrPayload: stage_q.payload <= cfg_data_i;
               default: ;
            endcase
            for (int unsigned i = 0; i < N_MON; i++) begin
               if (cfg_addr_i == CFG_AW'(16 + i)) mon_ptr_q[i] <= cfg_data_i;
            end
         end
         if (push) begin
            mem_q[wr_ptr_q] <= stage_q;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop) count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
         if (push_req && !push) ovf_q <= 1'b1;
         else if (wr_en && cfg_addr_i == AddrOvf) ovf_q <= 1'b0;
         // A fresh empty event outranks the clear-on-read of the old one.
         if (pop && !push && count_q == CW'(1)) tx_empty_q <= 1'b1;
         else if (rd_en && cfg_addr_i == AddrIrqRaw) tx_empty_q <= 1'b0;
         if (br_mon_clear_ack_i) clear_busy_q <= 1'b0;
         else if (mon_clr_start) clear_busy_q <= 1'b1;
         if (mon_clr_start) task_q <= cfg_data_i;
      end
   end

`ifdef DMNI_RCV_TIMESTAMP_EN
   logic [31:0] ts_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) ts_q <= '0;
      else if (eop_acked_i) ts_q <= rcv_timestamp_i;
   end
   assign ts_val = ts_q;
`else
   logic unused_ts;
   assign unused_ts = ^{eop_acked_i, rcv_timestamp_i};
   assign ts_val    = '0;
`endif

   assign cfg_data_o          = rdata_q;
   assign irq_o               = irq_q;
   assign br_req_o            = ~empty;
   assign br_service_o        = mem_q[rd_ptr_q].service;
   assign br_ksvc_o           = mem_q[rd_ptr_q].ksvc;
   assign br_target_o         = mem_q[rd_ptr_q].target;
   assign br_payload_o        = mem_q[rd_ptr_q].payload;
   assign br_mon_ptrs_o       = mon_ptr_q;
   assign br_mon_clear_o      = clear_busy_q;
   assign br_mon_task_clear_o = task_q;

endmodule

// File: tb/tb_dmni_ni_ctrl.sv
// Bench for dmni_ni_ctrl: directed literal checks plus randomized traffic against a queue-based model.
module tb_dmni_ni_ctrl;
   localparam int unsigned N_IRQ = 4, N_MON = 2, TX_DEPTH = 4, CFG_AW = 5;
   localparam int unsigned RW = N_IRQ + 2;

   logic                clk = 1'b0, rst_n = 1'b0;
   logic                cfg_en = 1'b0, cfg_we = 1'b0;
   logic [CFG_AW-1:0]   cfg_addr = '0;
   logic [31:0]         cfg_data = '0, cfg_data_o;
   logic [N_IRQ-1:0]    irq_src = '0;
   logic                irq_o, br_req_o, br_ack = 1'b0;
   logic [1:0]          br_service_o;
   logic [7:0]          br_ksvc_o;
   logic [15:0]         br_target_o;
   logic [31:0]         br_payload_o;
   logic [N_MON*32-1:0] br_mon_ptrs_o;
   logic                br_mon_clear_o, mon_ack = 1'b0, eop = 1'b0;
   logic [31:0]         br_mon_task_clear_o, ts_in = '0;

   always #5 clk = ~clk;

   dmni_ni_ctrl #(.N_IRQ(N_IRQ), .N_MON(N_MON), .TX_DEPTH(TX_DEPTH), .CFG_AW(CFG_AW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
      .cfg_data_i(cfg_data), .cfg_data_o(cfg_data_o), .irq_src_i(irq_src), .irq_o(irq_o),
      .br_req_o(br_req_o), .br_ack_i(br_ack), .br_service_o(br_service_o), .br_ksvc_o(br_ksvc_o),
      .br_target_o(br_target_o), .br_payload_o(br_payload_o), .br_mon_ptrs_o(br_mon_ptrs_o),
      .br_mon_clear_o(br_mon_clear_o), .br_mon_clear_ack_i(mon_ack),
      .br_mon_task_clear_o(br_mon_task_clear_o), .eop_acked_i(eop), .rcv_timestamp_i(ts_in)
   );

   int n_pass = 0, n_total = 0;
   logic chk_en = 1'b0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   // Model state: the TX queue is a plain SV queue of {service, ksvc, target, payload}.
   logic [57:0]   m_q[$];
   logic [1:0]    m_svc;
   logic [7:0]    m_ksvc;
   logic [15:0]   m_tgt;
   logic [31:0]   m_pay, m_task, m_rdata, m_ts;
   logic [RW-1:0] m_mask;
   logic          m_ovf, m_txe, m_busy, m_irq;
   logic [31:0]   m_ptr[N_MON];

   function automatic logic [31:0] model_read(int a);
      logic [RW-1:0] raw = {m_ovf, m_txe, irq_src};
      int sz = m_q.size();
      case (a)
         0: return {16'(sz), 13'b0, m_busy, sz == TX_DEPTH, sz == 0};
         1: return 32'(raw);
         2: return 32'(m_mask);
         3: return 32'(raw & m_mask);
         4: return 32'(m_svc);
         5: return 32'(m_ksvc);
         6: return 32'(m_tgt);
         7: return m_pay;
         9: return 32'(m_ovf);
         11: return m_ts;
         default: begin
            if (a >= 16 && a < 16 + N_MON) return m_ptr[a-16];
            return 32'h0;
         end
      endcase
   endfunction

   task automatic model_step();
      int a = int'(cfg_addr);
      int sz = m_q.size();
      logic wr, rd, pop, push_req, push_ok, clr_start;
      logic [31:0] rv;
      if (!rst_n) begin
         m_q.delete();
         {m_svc, m_ksvc, m_tgt, m_pay, m_task, m_rdata, m_ts} = '0;
         m_mask = '0;
         {m_ovf, m_txe, m_busy, m_irq} = '0;
         for (int i = 0; i < N_MON; i++) m_ptr[i] = '0;
         return;
      end
      wr = cfg_en && cfg_we;
      rd = cfg_en && !cfg_we;
      rv = model_read(a);
      pop = br_ack && sz > 0;
      push_req = wr && a == 8;
      push_ok = push_req && (sz < TX_DEPTH || pop);
      clr_start = wr && a == 10 && !m_busy;
      m_irq = |({m_ovf, m_txe, irq_src} & m_mask);
      if (rd) m_rdata = rv;
      if (push_req && !push_ok) m_ovf = 1'b1;
      else if (wr && a == 9) m_ovf = 1'b0;
      if (pop && !push_ok && sz == 1) m_txe = 1'b1;
      else if (rd && a == 1) m_txe = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push_ok) m_q.push_back({m_svc, m_ksvc, m_tgt, m_pay});
      if (mon_ack) m_busy = 1'b0;
      else if (clr_start) m_busy = 1'b1;
      if (clr_start) m_task = cfg_data;
      if (wr) begin
         if (a == 2) m_mask = cfg_data[RW-1:0];
         if (a == 4) m_svc = cfg_data[1:0];
         if (a == 5) m_ksvc = cfg_data[7:0];
         if (a == 6) m_tgt = cfg_data[15:0];
         if (a == 7) m_pay = cfg_data;
         if (a >= 16 && a < 16 + N_MON) m_ptr[a-16] = cfg_data;
      end
`ifdef DMNI_RCV_TIMESTAMP_EN
      if (eop) m_ts = ts_in;
`endif
   endtask

   // Every output is registered, so comparing on the falling edge is free of input races.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [N_MON*32-1:0] ptrs;
         for (int i = 0; i < N_MON; i++) ptrs[i*32 +: 32] = m_ptr[i];
         check("irq_o", irq_o, m_irq);
         check("br_req_o", br_req_o, m_q.size() != 0);
         if (m_q.size() != 0)
            check("br_head", {br_service_o, br_ksvc_o, br_target_o, br_payload_o}, m_q[0]);
         check("cfg_data_o", cfg_data_o, m_rdata);
         check("br_mon_clear_o", br_mon_clear_o, m_busy);
         check("br_mon_task", br_mon_task_clear_o, m_task);
         check("br_mon_ptrs", br_mon_ptrs_o, ptrs);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1 model_step();
      @(negedge clk);
   endtask

   task automatic wr(int a, logic [31:0] d);
      cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = CFG_AW'(a); cfg_data = d;
      tick();
      cfg_en = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic rd(int a, output logic [31:0] d);
      cfg_en = 1'b1; cfg_we = 1'b0; cfg_addr = CFG_AW'(a);
      tick();
      cfg_en = 1'b0;
      d = cfg_data_o;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] ts_exp;
      repeat (3) tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      check("reset irq_o", irq_o, 0);
      check("reset br_req_o", br_req_o, 0);
      rd(0, d); check("reset STATUS", d, 32'h0000_0001);

      irq_src = 4'b0100;
      tick(); check("irq masked", irq_o, 0);
      wr(2, 32'h4); check("irq before latency", irq_o, 0);
      tick(); check("irq unmasked", irq_o, 1);
      rd(3, d); check("IRQ_STATUS", d, 32'h4);
      irq_src = '0;

      for (int i = 0; i < 5; i++) begin
         wr(7, 32'hA0 + i);
         wr(8, 32'h0);
      end
      rd(0, d); check("STATUS full", d, 32'h0004_0002);
      rd(9, d); check("BR_OVF set", d, 32'h1);
      br_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("pop order", br_payload_o, 32'hA0 + i);
         tick();
      end
      br_ack = 1'b0;
      rd(1, d); check("IRQ_RAW ovf+empty", d, 32'h30);
      rd(1, d); check("IRQ_RAW empty cleared", d, 32'h20);
      wr(9, 32'h0);

      for (int i = 0; i < 4; i++) begin
         wr(7, 32'hB0 + i);
         wr(8, 32'h0);
      end
      wr(7, 32'hB4);
      cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = CFG_AW'(8); br_ack = 1'b1;
      tick();
      cfg_en = 1'b0; cfg_we = 1'b0; br_ack = 1'b0;
      rd(0, d); check("STATUS push+pop at full", d, 32'h0004_0002);
      rd(9, d); check("no overflow", d, 32'h0);
      br_ack = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check("push+pop order", br_payload_o, 32'hB0 + i);
         tick();
      end
      br_ack = 1'b0;
      rd(1, d);

      wr(10, 32'h12);
      check("mon clear req", br_mon_clear_o, 1);
      check("mon task", br_mon_task_clear_o, 32'h12);
      rd(0, d); check("STATUS clear_busy", d, 32'h0000_0005);
      wr(10, 32'h34);
      check("mon task held", br_mon_task_clear_o, 32'h12);
      mon_ack = 1'b1; tick(); mon_ack = 1'b0;
      check("mon clear dropped", br_mon_clear_o, 0);

      ts_in = 32'h1234; eop = 1'b1; tick(); eop = 1'b0;
`ifdef DMNI_RCV_TIMESTAMP_EN
      ts_exp = 32'h1234;
`else
      ts_exp = 32'h0;
`endif
      rd(11, d); check("RCV_TIMESTAMP", d, ts_exp);

      for (int n = 0; n < 3000; n++) begin
         int sel = $urandom_range(0, 15);
         cfg_en = ($urandom_range(0, 3) != 0);
         cfg_we = $urandom_range(0, 1) == 1;
         case (sel)
            12: cfg_addr = CFG_AW'(16);
            13: cfg_addr = CFG_AW'(17);
            14: cfg_addr = CFG_AW'($urandom_range(0, 31));
            15: cfg_addr = CFG_AW'(8);
            default: cfg_addr = CFG_AW'(sel);
         endcase
         cfg_data = $urandom;
         br_ack = ($urandom_range(0, 2) == 0);
         mon_ack = ($urandom_range(0, 7) == 0);
         eop = ($urandom_range(0, 7) == 0);
         ts_in = $urandom;
         if ($urandom_range(0, 3) == 0) irq_src = N_IRQ'($urandom);
         tick();
      end
      cfg_en = 1'b0; br_ack = 1'b0; mon_ack = 1'b0; eop = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
